// File: rtl/vga_capture.sv
`default_nettype none
// ===========================================================================
// vga_capture : VGA sync lock + 2:1 decimating frame-buffer writer.
// Optional macro CAPTURE_CRC_EN adds frame_crc.                    Rev 1.0
// ===========================================================================
module vga_capture #(
   parameter int H_TOTAL = 800,
   parameter int V_TOTAL = 525,
   parameter int H_START = 144,
   parameter int V_START = 34,
   parameter int H_ACT   = 640,
   parameter int V_ACT   = 480
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic        hsync,
   input  logic        vsync,
   input  logic [11:0] rgb,
   output logic        wr_en,
   output logic [16:0] wr_addr,
   output logic [11:0] wr_data,
   output logic        locked,
   output logic        frame_done
`ifdef CAPTURE_CRC_EN
   ,
   output logic [15:0] frame_crc
`endif
);

   localparam logic [10:0] C_H_LEN     = 11'(H_TOTAL);
   localparam logic [10:0] C_V_LEN     = 11'(V_TOTAL);
   localparam logic [9:0]  C_H_BEG     = 10'(H_START);
   localparam logic [9:0]  C_H_END     = 10'(H_START + H_ACT);
   localparam logic [9:0]  C_V_BEG     = 10'(V_START);
   localparam logic [9:0]  C_V_END     = 10'(V_START + V_ACT);
   localparam logic [16:0] C_ROW_WORDS = 17'(H_ACT / 2);
   localparam logic [16:0] C_LAST_ADDR = 17'((H_ACT / 2) * (V_ACT / 2) - 1);

   typedef enum logic [1:0] {
      SEARCH = 2'd0,
      VERIFY = 2'd1,
      LOCKED = 2'd2
   } state_t;

   state_t      state, state_nxt;
   logic        s_hs, s_vs, p_hs, p_vs;
   logic [11:0] s_rgb;
   logic        vs_pend, frame_en;
   logic [9:0]  h_pos, v_pos;

   logic        hs_fall, vs_fall, align, line_ok, frame_ok, active, wr_now;
   logic [9:0]  h_nxt, v_nxt, ha, va;
   logic [16:0] addr_nxt;

   assign hs_fall  = p_hs & ~s_hs;
   assign vs_fall  = p_vs & ~s_vs;
   // A vsync fall on the same clock as the hsync fall already counts as pending.
   assign align    = hs_fall & (vs_pend | vs_fall);
   assign line_ok  = ({1'b0, h_pos} + 11'd1) == C_H_LEN;
   assign frame_ok = ({1'b0, v_pos} + 11'd1) == C_V_LEN;

   assign h_nxt = hs_fall ? 10'd0 : ((h_pos == 10'h3FF) ? h_pos : h_pos + 10'd1);
   assign v_nxt = align   ? 10'd0 :
                  hs_fall ? ((v_pos == 10'h3FF) ? v_pos : v_pos + 10'd1) : v_pos;

   // The next-state counters describe the pixel currently held in s_rgb.
   assign ha       = h_nxt - C_H_BEG;
   assign va       = v_nxt - C_V_BEG;
   assign active   = (h_nxt >= C_H_BEG) && (h_nxt < C_H_END) &&
                     (v_nxt >= C_V_BEG) && (v_nxt < C_V_END);
   assign wr_now   = (state == LOCKED) && frame_en && active && !ha[0] && !va[0];
   assign addr_nxt = 17'(va[9:1]) * C_ROW_WORDS + 17'(ha[9:1]);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s_hs       <= 1'b0;
         s_vs       <= 1'b0;
         p_hs       <= 1'b0;
         p_vs       <= 1'b0;
         s_rgb      <= 12'h000;
         vs_pend    <= 1'b0;
         frame_en   <= 1'b0;
         h_pos      <= 10'd0;
         v_pos      <= 10'd0;
         wr_en      <= 1'b0;
         wr_addr    <= 17'd0;
         wr_data    <= 12'h000;
         frame_done <= 1'b0;
      end else begin
         s_hs       <= hsync;
         s_vs       <= vsync;
         p_hs       <= s_hs;
         p_vs       <= s_vs;
         s_rgb      <= rgb;
         vs_pend    <= (vs_pend | vs_fall) & ~align;
         h_pos      <= h_nxt;
         v_pos      <= v_nxt;
         if (align)
            frame_en <= en;
         wr_en      <= wr_now;
         if (wr_now) begin
            wr_addr <= addr_nxt;
            wr_data <= s_rgb;
         end
         frame_done <= wr_now && (addr_nxt == C_LAST_ADDR);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= SEARCH;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      locked    = 1'b0;
      case (state)
         SEARCH: begin
            if (align)
               state_nxt = VERIFY;
         end
         VERIFY: begin
            if (align) begin
               if (frame_ok)
                  state_nxt = LOCKED;
            end else if (hs_fall && !line_ok) begin
               state_nxt = SEARCH;
            end
         end
         LOCKED: begin
            locked = 1'b1;
            if (hs_fall && (!line_ok || (align && !frame_ok)))
               state_nxt = SEARCH;
         end
         default: state_nxt = SEARCH;
      endcase
   end

`ifdef CAPTURE_CRC_EN
   // CRC-16-CCITT, 12 data bits per step, MSB first.
   function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [11:0] d);
      logic [15:0] r;
      r = c;
      for (int i = 11; i >= 0; i--)
         r = {r[14:0], 1'b0} ^ ((r[15] ^ d[i]) ? 16'h1021 : 16'h0000);
      return r;
   endfunction

   logic [15:0] crc_acc;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         crc_acc   <= 16'hFFFF;
         frame_crc <= 16'h0000;
      end else begin
         if (align)
            crc_acc <= 16'hFFFF;
         else if (wr_now)
            crc_acc <= crc_step(crc_acc, s_rgb);
         if (frame_done)
            frame_crc <= crc_acc;
      end
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_vga_capture.sv
`default_nettype none
// tb_vga_capture : directed checks of vga_capture on a scaled-down video
// geometry (40x30 total, 16x12 active) so that each frame is 1200 clocks.
`timescale 1ns/1ps
module tb_vga_capture;
   localparam int HT = 40, VT = 30, HS = 8, VS = 4, HA = 16, VA = 12;
   localparam int WORDS = (HA / 2) * (VA / 2);
   localparam logic [16:0] LAST = 17'(WORDS - 1);

   logic        clk = 1'b0;
   logic        rst, en, hsync, vsync;
   logic [11:0] rgb;
   logic        wr_en, locked, frame_done;
   logic [16:0] wr_addr;
   logic [11:0] wr_data;
`ifdef CAPTURE_CRC_EN
   logic [15:0] frame_crc;
   logic [15:0] crc_exp;
`endif

   vga_capture #(
      .H_TOTAL(HT), .V_TOTAL(VT), .H_START(HS),
      .V_START(VS), .H_ACT(HA), .V_ACT(VA)
   ) dut (
      .clk(clk), .rst(rst), .en(en), .hsync(hsync), .vsync(vsync), .rgb(rgb),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .locked(locked), .frame_done(frame_done)
`ifdef CAPTURE_CRC_EN
      , .frame_crc(frame_crc)
`endif
   );

   always #20 clk = ~clk;

   // ---------------- video source ----------------
   int hc = 0, vc = 0, frame_cnt = 0;
   bit stretch_req = 1'b0, vs_both = 1'b0, rgb_const = 1'b0;

   initial begin
      hsync = 1'b1; vsync = 1'b1; rgb = 12'h000;
      forever begin
         @(posedge clk); #1;
         if (hc == 0 && vc == 0) frame_cnt++;
         hsync = (hc >= 4);
         if (vs_both)
            vsync = !(vc < 2);
         else
            vsync = !((vc == VT - 1 && hc >= HT / 2) || vc == 0 || (vc == 1 && hc < HT / 2));
         if (hc >= HS && hc < HS + HA && vc >= VS && vc < VS + VA)
            rgb = rgb_const ? 12'hF00 : {4'(hc - HS), 4'(vc - VS), 4'h5};
         else
            rgb = 12'h000;
         if (stretch_req && hc == HT - 1)
            stretch_req = 1'b0;              // repeat last clock once: 41-clock line
         else if (hc == HT - 1) begin
            hc = 0;
            vc = (vc == VT - 1) ? 0 : vc + 1;
         end else
            hc++;
      end
   end

   // ---------------- write monitor ----------------
   int n_wr, n_done, n_done_last, n_bad_order, n_wr_unlocked, n_unlock;
   logic [16:0] first_addr, last_addr;
   logic [11:0] first_data, last_data, data_a1;

   task automatic clear_stats();
      n_wr = 0; n_done = 0; n_done_last = 0; n_bad_order = 0;
      n_wr_unlocked = 0; n_unlock = 0;
      first_addr = '1; last_addr = '1; first_data = '1; last_data = '1; data_a1 = '1;
   endtask

   always @(negedge clk) begin
      if (wr_en) begin
         if (n_wr == 0) begin
            first_addr = wr_addr;
            first_data = wr_data;
         end else if (wr_addr <= last_addr)
            n_bad_order++;
         if (wr_addr == 17'd1) data_a1 = wr_data;
         last_addr = wr_addr;
         last_data = wr_data;
         n_wr++;
         if (!locked) n_wr_unlocked++;
      end
      if (frame_done) begin
         n_done++;
         if (wr_en && wr_addr == LAST) n_done_last++;
      end
      if (!locked) n_unlock++;
   end

   // ---------------- checking helpers ----------------
   int n_chk = 0, n_err = 0;
   int f_rel, t;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_frame();
      int f0 = frame_cnt;
      int k = 0;
      do begin @(posedge clk); #2; k++; end while (frame_cnt == f0 && k < 3 * HT * VT);
      check("frame_wait", (frame_cnt != f0) ? 32'd1 : 32'd0, 32'd1);
   endtask

   task automatic wait_line(input int v);
      int k = 0;
      do begin @(posedge clk); #2; k++; end while (!(vc == v && hc == 1) && k < 3 * HT * VT);
      check("line_wait", (vc == v) ? 32'd1 : 32'd0, 32'd1);
   endtask

   task automatic wait_lock();
      int k = 0;
      while (!locked && k < 5 * HT * VT) begin @(posedge clk); #2; k++; end
      check("lock_acquired", 32'(locked), 32'd1);
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_wr_en"},   32'(wr_en),      32'd0);
      check({tag, "_wr_addr"}, 32'(wr_addr),    32'd0);
      check({tag, "_wr_data"}, 32'(wr_data),    32'd0);
      check({tag, "_locked"},  32'(locked),     32'd0);
      check({tag, "_done"},    32'(frame_done), 32'd0);
   endtask

   function automatic logic [15:0] crc_golden(input int words, input logic [11:0] w);
      logic [15:0] c;
      c = 16'hFFFF;
      for (int k = 0; k < words; k++) begin
         c = c ^ {w, 4'h0};
         for (int b = 0; b < 12; b++)
            c = c[15] ? ({c[14:0], 1'b0} ^ 16'h1021) : {c[14:0], 1'b0};
      end
      return c;
   endfunction

   // ---------------- directed sequence ----------------
   initial begin
      clear_stats();
      rst = 1'b1; en = 1'b1;
      repeat (5) @(posedge clk); #2;
      check_outputs_zero("reset");

      // Acquire lock with nominal timing (vsync falls mid-line).
      wait_line(2);
      rst = 1'b0;
      f_rel = frame_cnt;
      wait_lock();
      check("lock_at_2nd_align", 32'(frame_cnt - f_rel), 32'd2);
      clear_stats();
      wait_frame();
      check("f1_writes",      32'(n_wr),        32'(WORDS));
      check("f1_first_addr",  32'(first_addr),  32'd0);
      check("f1_first_data",  32'(first_data),  32'h005);
      check("f1_addr1_data",  32'(data_a1),     32'h205);
      check("f1_last_addr",   32'(last_addr),   32'(LAST));
      check("f1_last_data",   32'(last_data),   32'hEA5);
      check("f1_done_count",  32'(n_done),      32'd1);
      check("f1_done_last",   32'(n_done_last), 32'd1);
      check("f1_order",       32'(n_bad_order), 32'd0);
      check("f1_locked",      32'(locked),      32'd1);

      // Stretch line 6 to 41 clocks: lock lost at the start of line 7.
      clear_stats();
      wait_line(6);
      stretch_req = 1'b1;
      wait_line(8);
      check("stretch_unlock", 32'(locked), 32'd0);
      wait_frame();
      check("stretch_writes",      32'(n_wr),          32'd16);
      check("stretch_no_done",     32'(n_done),        32'd0);
      check("stretch_wr_unlocked", 32'(n_wr_unlocked), 32'd0);

      // One clean verify frame, then relock and a full capture.
      clear_stats();
      wait_line(2);
      check("verify_unlocked", 32'(locked), 32'd0);
      wait_frame();
      check("verify_writes", 32'(n_wr), 32'd0);
      repeat (4) @(posedge clk); #2;
      check("relock", 32'(locked), 32'd1);
      clear_stats();
      wait_frame();
      check("relock_writes", 32'(n_wr),   32'(WORDS));
      check("relock_done",   32'(n_done), 32'd1);

      // en low only around the alignment: that frame is skipped, lock held.
      wait_line(VT - 1);
      en = 1'b0;
      wait_frame();
      clear_stats();
      wait_line(5);
      en = 1'b1;
      wait_frame();
      check("en0_writes",  32'(n_wr),     32'd0);
      check("en0_done",    32'(n_done),   32'd0);
      check("en0_lockgap", 32'(n_unlock), 32'd0);
      clear_stats();
      wait_frame();
      check("en1_writes", 32'(n_wr),   32'(WORDS));
      check("en1_done",   32'(n_done), 32'd1);

      // Asynchronous reset mid-frame for 3 clocks.
      wait_line(6);
      repeat (10) @(posedge clk); #3;
      rst = 1'b1;
      #1;
      check_outputs_zero("midrst");
      repeat (3) @(posedge clk); #3;
      rst = 1'b0;
      clear_stats();
      wait_frame();
      wait_frame();
      check("midrst_verify_writes", 32'(n_wr), 32'd0);
      clear_stats();
      wait_frame();
      check("midrst_writes", 32'(n_wr),   32'(WORDS));
      check("midrst_done",   32'(n_done), 32'd1);

      // hsync and vsync falling on the same clock, lock reacquired from reset.
      wait_line(6);
      vs_both = 1'b1;
      rst = 1'b1;
      repeat (3) @(posedge clk); #3;
      rst = 1'b0;
      f_rel = frame_cnt;
      wait_lock();
      check("both_lock_at_2nd_align", 32'(frame_cnt - f_rel), 32'd2);
      clear_stats();
      wait_frame();
      check("both_writes",     32'(n_wr),        32'(WORDS));
      check("both_first_addr", 32'(first_addr),  32'd0);
      check("both_first_data", 32'(first_data),  32'h005);
      check("both_last_addr",  32'(last_addr),   32'(LAST));
      check("both_done_last",  32'(n_done_last), 32'd1);

`ifdef CAPTURE_CRC_EN
      // Constant 12'hF00 frame.
      wait_line(20);
      rgb_const = 1'b1;
      wait_frame();
      wait_frame();
      crc_exp = crc_golden(WORDS, 12'hF00);
      check("crc_value", 32'(frame_crc), 32'(crc_exp));
      wait_line(10);
      check("crc_stable", 32'(frame_crc), 32'(crc_exp));
`endif

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
